// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_rx_link_ctrl
//
// Receive-side link sequencing controller for the 10GBASE-R PCS (rx_clk domain).
// Pulses a reset into the RX datapath, waits for block lock with a clear BER
// monitor, qualifies the lock over a stability window and then declares the
// link up. Loss of lock, high BER or a SERDES reset request tears the link
// down and restarts. Repeated lock timeouts latch a fault until the block is
// disabled.
//
// Optional feature macro: ETH_PHY_10G_RX_LINK_STATS_EN
//   defined   -> bad_block_count counts rx_bad_block strobes while UP
//   undefined -> bad_block_count tied to 0, stats_clear ignored
//
// Ports:
//   rx_clk               in   clock, rising edge
//   rx_rst               in   synchronous active-high reset
//   cfg_enable           in   1 = run sequencing, 0 = return to IDLE
//   rx_block_lock        in   block lock from PCS RX
//   rx_high_ber          in   high-BER flag from PCS RX
//   rx_bad_block         in   one-cycle bad-block strobe
//   serdes_rx_reset_req  in   PCS request to reset the SERDES
//   stats_clear          in   synchronous clear of bad_block_count
//   pcs_rx_reset         out  reset to the RX datapath
//   link_up              out  link qualified
//   link_fault           out  retries exhausted
//   link_state     [2:0] out  encoded FSM state
//   relock_count   [7:0] out  UP->RESET transitions, saturating
//   bad_block_count[15:0] out bad blocks seen while UP, saturating
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE  (0) | disabled, waiting for cfg_enable
// RESET (1) | pcs_rx_reset asserted for RESET_CYCLES
// WAIT_LOCK(2)| waiting for lock with clean BER, up to LOCK_TIMEOUT cycles
// QUALIFY(3)| lock must hold clean for STABLE_CYCLES
// UP    (4) | link qualified
// FAULT (5) | retries exhausted, held until cfg_enable drops
// -----------------------------------------------------------------------------
module eth_phy_10g_rx_link_ctrl #(
    parameter int RESET_CYCLES  = 4,
    parameter int LOCK_TIMEOUT  = 256,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic        rx_clk,
    input  logic        rx_rst,
    input  logic        cfg_enable,
    input  logic        rx_block_lock,
    input  logic        rx_high_ber,
    input  logic        rx_bad_block,
    input  logic        serdes_rx_reset_req,
    input  logic        stats_clear,
    output logic        pcs_rx_reset,
    output logic        link_up,
    output logic        link_fault,
    output logic [2:0]  link_state,
    output logic [7:0]  relock_count,
    output logic [15:0] bad_block_count
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESET     = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_QUALIFY   = 3'd3;
    localparam logic [2:0] ST_UP        = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    // One shared timer sized for the longest timed state.
    localparam int T_A  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX = (T_A > STABLE_CYCLES) ? T_A : STABLE_CYCLES;
    localparam int TW   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] LD_RESET  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] LD_LOCK   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] LD_STABLE = TW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    logic [2:0]    state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [3:0]    retry_q,   retry_d;
    logic [7:0]    relock_q,  relock_d;
    logic [3:0]    retry_inc;
    logic          lock_good;
    logic          timer_done;

    assign retry_inc  = retry_q + 4'd1;
    assign lock_good  = rx_block_lock & ~rx_high_ber;
    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_done ? timer_q : timer_q - TW'(1);
        retry_d  = retry_q;
        relock_d = relock_q;

        if (!cfg_enable) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    timer_d = LD_RESET;
                    retry_d = '0;
                end
                ST_RESET: begin
                    if (timer_done) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = LD_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (lock_good) begin
                        state_d = ST_QUALIFY;
                        timer_d = LD_STABLE;
                    end else if (timer_done) begin
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_LIM) begin
                            state_d = ST_FAULT;
                            timer_d = '0;
                        end else begin
                            state_d = ST_RESET;
                            timer_d = LD_RESET;
                        end
                    end
                end
                ST_QUALIFY: begin
                    // A glitch in the final window cycle still blocks promotion.
                    if (!lock_good) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = LD_LOCK;
                    end else if (timer_done) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end
                end
                ST_UP: begin
                    if (!lock_good || serdes_rx_reset_req) begin
                        state_d = ST_RESET;
                        timer_d = LD_RESET;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            retry_q  <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
        end
    end

    assign pcs_rx_reset = (state_q == ST_RESET);
    assign link_up      = (state_q == ST_UP);
    assign link_fault   = (state_q == ST_FAULT);
    assign link_state   = state_q;
    assign relock_count = relock_q;

`ifdef ETH_PHY_10G_RX_LINK_STATS_EN
    logic [15:0] bad_cnt_q, bad_cnt_d;

    // Clear takes precedence over a coincident strobe.
    always_comb begin
        bad_cnt_d = bad_cnt_q;
        if (stats_clear) begin
            bad_cnt_d = '0;
        end else if (rx_bad_block && (state_q == ST_UP) && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            bad_cnt_q <= '0;
        end else begin
            bad_cnt_q <= bad_cnt_d;
        end
    end

    assign bad_block_count = bad_cnt_q;
`else
    logic unused_stats_inputs;
    assign unused_stats_inputs = rx_bad_block ^ stats_clear;
    assign bad_block_count     = '0;
`endif

endmodule

// File: doc/eth_phy_10g_rx_link_ctrl.md
# eth_phy_10g_rx_link_ctrl

Receive-side link sequencing controller for the 10GBASE-R PCS. Sits beside the `eth_phy_10g` RX path in the `rx_clk` domain. Issues timed resets to the RX datapath, waits for block lock and a clear BER monitor, and qualifies the link over a stability window before declaring it up. It also tears the link down and retries when lock or BER degrades, and latches a fault after a bounded number of failed attempts.

## Interface
Parameters:
- RESET_CYCLES, 4: `pcs_rx_reset` pulse length in cycles (≥1).
- LOCK_TIMEOUT, 256: cycles allowed in WAIT_LOCK before a retry (≥1).
- STABLE_CYCLES, 64: cycles lock must hold with `rx_high_ber` low before link up (≥1).
- MAX_RETRIES, 3: consecutive lock timeouts before FAULT (1–15).

Ports:
- rx_clk  in  1  clock; all logic on rising edge.
- rx_rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  1 = run sequencing; 0 = return to IDLE.
- rx_block_lock  in  1  block lock from PCS RX.
- rx_high_ber  in  1  high-BER flag from PCS RX.
- rx_bad_block  in  1  one-cycle bad-block strobe.
- serdes_rx_reset_req  in  1  PCS request to reset the SERDES.
- stats_clear  in  1  synchronous clear of `bad_block_count`.
- pcs_rx_reset  out  1  reset to the RX datapath.
- link_up  out  1  link qualified.
- link_fault  out  1  retries exhausted.
- link_state  out  3  encoded FSM state.
- relock_count  out  8  UP→RESET transitions; saturates at 255.
- bad_block_count  out  16  bad blocks seen while UP; saturates at 65535.

## Operation
- Moore FSM. States and `link_state` codes: IDLE=0, RESET=1, WAIT_LOCK=2, QUALIFY=3, UP=4, FAULT=5.
- Output decode: `pcs_rx_reset` = (state==RESET); `link_up` = (state==UP); `link_fault` = (state==FAULT).
- Single down-counter `timer`. It is loaded with N-1 on state entry; the state exits when `timer`==0, so each timed state lasts exactly N cycles.
- `retry_cnt` is a 4-bit internal counter.
- Priority, highest first: `rx_rst`, then `cfg_enable`==0 (next state IDLE from any state), then the per-state rules below.
- IDLE: if `cfg_enable`, go to RESET and clear `retry_cnt`.
- RESET: after RESET_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: `rx_block_lock`=1 and `rx_high_ber`=0 → QUALIFY.
  - On timeout: `retry_cnt`+1. If the new value equals MAX_RETRIES → FAULT; otherwise → RESET.
  - Lock has priority over a timeout in the same cycle.
- QUALIFY: `rx_block_lock`=0 or `rx_high_ber`=1 → WAIT_LOCK. The timer reloads LOCK_TIMEOUT and `retry_cnt` is unchanged.
  - Full STABLE_CYCLES window elapses → UP and clear `retry_cnt`.
  - A loss of lock in the final cycle has priority over promotion to UP.
- UP: `rx_block_lock`=0, `rx_high_ber`=1 or `serdes_rx_reset_req`=1 → RESET and `relock_count`+1 (saturating).
- FAULT: held until `cfg_enable`=0.
- `relock_count` is cleared only by `rx_rst`.
- Reset values: state IDLE; `timer`, `retry_cnt`, `relock_count` and `bad_block_count` = 0; every output 0.

## Timing
- All outputs are registered or decoded from registered state, with no combinational input-to-output path.
- `cfg_enable` rising, sampled at edge k: `pcs_rx_reset` is high in cycles k+1 … k+RESET_CYCLES.
- Lock present at the first WAIT_LOCK cycle: `link_up` rises STABLE_CYCLES+1 cycles after WAIT_LOCK entry. That is one WAIT_LOCK cycle plus STABLE_CYCLES in QUALIFY.
- Loss of lock in UP, sampled at edge k: `link_up` falls and `pcs_rx_reset` rises at k+1.
- `cfg_enable` falling, sampled at edge k: state is IDLE at k+1 from any state, including mid-RESET. The `pcs_rx_reset` pulse is truncated.
- `rx_rst` mid-operation: all state returns to reset values at the next edge.
- `rx_bad_block` sampled in UP at edge k: `bad_block_count` updates at k+1.
- `stats_clear` coincident with `rx_bad_block`: clear wins and the count is 0.

## Configuration
- `ETH_PHY_10G_RX_LINK_STATS_EN` defined: `bad_block_count` is implemented.
  - It increments on `rx_bad_block` only while state==UP, saturates at 16'hFFFF, and clears on `stats_clear` or `rx_rst`.
- Undefined: the counter is not built, `bad_block_count` is tied to 0 and `stats_clear` is ignored.
- FSM, `relock_count` and all other behaviour are identical in both builds.

## Test plan
- Defaults, `cfg_enable`=1, lock held high from the start: `pcs_rx_reset` is high for 4 cycles, `link_up` rises 65 cycles after WAIT_LOCK entry, and `link_state` passes 1→2→3→4.
- `rx_block_lock` held 0 throughout: RESET/WAIT_LOCK cycles 3 times, then `link_fault`=1 and `link_state`=5 persist. Dropping `cfg_enable` gives `link_state`=0 on the next cycle.
- Lock lost for one cycle at QUALIFY cycle 63 → back to WAIT_LOCK, no `link_up`, `relock_count`=0. Lock then restored → `link_up` after 64 QUALIFY cycles.
- From UP, pulse `rx_high_ber` once, then pulse `serdes_rx_reset_req` once after relink → `relock_count`=2 and two 4-cycle `pcs_rx_reset` pulses.
- With STATS_EN: 10 `rx_bad_block` strobes in UP plus 5 outside UP → `bad_block_count`=10. Then `stats_clear` coincident with a strobe → 0.
- Force `bad_block_count` near saturation with 70000 strobes → count holds at 65535. Repeat the same stimulus with the macro undefined → count stays 0.
